// File: rtl/emc_axis_encoder_capture.sv
// Per-axis quadrature encoder counter with preset, sticky illegal-transition flag
// and a one-shot position latch armed by capen.
//
// state   | meaning
// S_IDLE  | not armed, capok low
// S_ARMED | waiting for a qualified cap_in edge
// S_DONE  | position latched, capok high until capen drops
module emc_axis_encoder_capture #(
  parameter int unsigned FILT_LEN = 4,
  parameter bit          CAP_EDGE = 1'b0,
  parameter bit          DIR_INV  = 1'b0
) (
  input  logic        clk_100M,
  input  logic        n_rst,
  input  logic        enc_a_i,
  input  logic        enc_b_i,
  input  logic        cap_in_i,
  input  logic        ecdrst_i,
  input  logic [31:0] ecdrst_value_i,
  input  logic        capen_i,
  output logic [31:0] ecd_value_o,
  output logic [31:0] cap_value_o,
  output logic        capok_o,
  output logic        quad_err_o
);

  localparam int unsigned CH_CAP = 0;
  localparam int unsigned CH_B   = 1;
  localparam int unsigned CH_A   = 2;

  localparam logic [3:0] FILT_RLD = 4'(FILT_LEN - 1);
  localparam logic [4:0] INIT_RLD = 5'(FILT_LEN + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } cap_state_e;

  logic [2:0]      pin_w;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      filt_q, filt_d;
  logic [2:0][3:0] flt_cnt_q, flt_cnt_d;
  logic [4:0]      init_cnt_q, init_cnt_d;
  logic            init_done_q, init_done_d;
  logic [1:0]      prev_ab_q;
  logic            cap_prev_q;
  logic            ecdrst_q, capen_q;
  logic [31:0]     ecd_q, ecd_d;
  logic [31:0]     cap_q, cap_d;
  logic            quad_err_q, quad_err_d;
  cap_state_e      state_q, state_d;

  logic [1:0]      ab_w, phase_w;
  logic            step_fwd, step_rev, illegal_w;
  logic            count_up, count_dn;
  logic            preset_w, capen_rise_w, cap_edge_w, cap_load_w;

  assign pin_w = {enc_a_i, enc_b_i, cap_in_i};

  // Filter timer reloads on every matching sample, so any bounce restarts it.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = flt_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        flt_cnt_d[i] = FILT_RLD;
      end else if (flt_cnt_q[i] == 4'd0) begin
        filt_d[i]    = sync2_q[i];
        flt_cnt_d[i] = FILT_RLD;
      end else begin
        flt_cnt_d[i] = flt_cnt_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (!init_done_q) begin
      if (init_cnt_q == 5'd0) init_done_d = 1'b1;
      else                    init_cnt_d  = init_cnt_q - 5'd1;
    end
  end

  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   quad_pos = 2'd0;
      2'b01:   quad_pos = 2'd1;
      2'b11:   quad_pos = 2'd2;
      default: quad_pos = 2'd3;
    endcase
  endfunction

  assign ab_w    = {filt_q[CH_A], filt_q[CH_B]};
  assign phase_w = quad_pos(ab_w) - quad_pos(prev_ab_q);

  always_comb begin
    step_fwd  = 1'b0;
    step_rev  = 1'b0;
    illegal_w = 1'b0;
    if (init_done_q) begin
      case (phase_w)
        2'd1:    step_fwd  = 1'b1;
        2'd3:    step_rev  = 1'b1;
        2'd2:    illegal_w = 1'b1;
        default: ;
      endcase
    end
  end

  assign count_up = DIR_INV ? step_rev : step_fwd;
  assign count_dn = DIR_INV ? step_fwd : step_rev;
  assign preset_w = ecdrst_i & ~ecdrst_q;

  always_comb begin
    ecd_d = ecd_q;
    if (preset_w)      ecd_d = ecdrst_value_i;
    else if (count_up) ecd_d = ecd_q + 32'd1;
    else if (count_dn) ecd_d = ecd_q - 32'd1;
    quad_err_d = preset_w ? 1'b0 : (quad_err_q | illegal_w);
  end

  // capen_q resets low so a level already high out of reset arms the latch.
  assign capen_rise_w = capen_i & ~capen_q;
  assign cap_edge_w   = init_done_q && (filt_q[CH_CAP] != cap_prev_q) &&
                        (filt_q[CH_CAP] == ~CAP_EDGE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (capen_rise_w) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!capen_i)        state_d = S_IDLE;
        else if (cap_edge_w) state_d = S_DONE;
      end
      S_DONE: begin
        if (!capen_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    capok_o    = (state_q == S_DONE);
    cap_load_w = (state_q == S_ARMED) && capen_i && cap_edge_w;
  end

  assign cap_d = cap_load_w ? ecd_q : cap_q;

  always_ff @(posedge clk_100M or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      flt_cnt_q   <= {3{FILT_RLD}};
      init_cnt_q  <= INIT_RLD;
      init_done_q <= 1'b0;
      prev_ab_q   <= '0;
      cap_prev_q  <= 1'b0;
      ecdrst_q    <= 1'b0;
      capen_q     <= 1'b0;
      ecd_q       <= '0;
      cap_q       <= '0;
      quad_err_q  <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      sync1_q     <= pin_w;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      prev_ab_q   <= ab_w;
      cap_prev_q  <= filt_q[CH_CAP];
      ecdrst_q    <= ecdrst_i;
      capen_q     <= capen_i;
      ecd_q       <= ecd_d;
      cap_q       <= cap_d;
      quad_err_q  <= quad_err_d;
      state_q     <= state_d;
    end
  end

  assign ecd_value_o = ecd_q;
  assign cap_value_o = cap_q;
  assign quad_err_o  = quad_err_q;

endmodule

// File: tb/tb_emc_axis_encoder_capture.sv
// Bench for emc_axis_encoder_capture: randomized quadrature stimulus, a step-count
// reference model, and a scoreboard that checks every ecd_value change and its timing.
`timescale 1ns/1ps
module tb_emc_axis_encoder_capture;
  localparam int FILT_LEN = 4;
  localparam int LAT      = FILT_LEN + 3;

  typedef struct {
    logic [31:0] value;
    int          due;
  } exp_t;

  logic        clk_100M = 1'b0;
  logic        n_rst = 1'b0;
  logic        enc_a = 1'b1;
  logic        enc_b = 1'b1;
  logic        cap_in = 1'b0;
  logic        ecdrst = 1'b0;
  logic        capen = 1'b0;
  logic [31:0] ecdrst_value = '0;
  logic [31:0] ecd_value_o, cap_value_o;
  logic        capok_o, quad_err_o;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] model_cnt = '0;
  int          phase = 2;
  logic [1:0]  pin_tbl [4];

  emc_axis_encoder_capture #(
    .FILT_LEN(FILT_LEN),
    .CAP_EDGE(1'b0),
    .DIR_INV (1'b0)
  ) dut (
    .clk_100M      (clk_100M),
    .n_rst         (n_rst),
    .enc_a_i       (enc_a),
    .enc_b_i       (enc_b),
    .cap_in_i      (cap_in),
    .ecdrst_i      (ecdrst),
    .ecdrst_value_i(ecdrst_value),
    .capen_i       (capen),
    .ecd_value_o   (ecd_value_o),
    .cap_value_o   (cap_value_o),
    .capok_o       (capok_o),
    .quad_err_o    (quad_err_o)
  );

  always #5 clk_100M = ~clk_100M;
  always @(posedge clk_100M) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic push_exp(input logic [31:0] v, input int due);
    exp_t e;
    e.value = v;
    e.due   = due;
    exp_q.push_back(e);
  endtask

  // One quadrature step in the requested direction; the count follows the intent.
  task automatic step(input int dir);
    @(negedge clk_100M);
    phase = (phase + dir) & 3;
    {enc_a, enc_b} = pin_tbl[phase];
    model_cnt = model_cnt + 32'(dir);
    push_exp(model_cnt, cyc + LAT);
    tick($urandom_range(40, FILT_LEN + 4));
  endtask

  task automatic preset(input logic [31:0] v);
    @(negedge clk_100M);
    ecdrst = 1'b0;
    ecdrst_value = v;
    @(negedge clk_100M);
    ecdrst = 1'b1;
    if (v != model_cnt) push_exp(v, cyc + 1);
    model_cnt = v;
    tick(3);
  endtask

  // Scoreboard monitor: every observed change of ecd_value must match the next expectation.
  initial begin
    logic [31:0] last;
    exp_t        e;
    last = '0;
    forever begin
      @(negedge clk_100M);
      if (n_rst && ecd_value_o !== last) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL ecd_unexpected: got %h at cycle %0d, expected no change", ecd_value_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (ecd_value_o === e.value && cyc == e.due) n_pass++;
          else $display("FAIL ecd_step: got %h at cycle %0d, expected %h at cycle %0d",
                        ecd_value_o, cyc, e.value, e.due);
        end
      end
      last = ecd_value_o;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int glen;
    pin_tbl[0] = 2'b00;
    pin_tbl[1] = 2'b01;
    pin_tbl[2] = 2'b11;
    pin_tbl[3] = 2'b10;

    // Pins held at 11 through reset must not count or flag an error.
    tick(5);
    check32("rst_ecd", ecd_value_o, 32'd0);
    check32("rst_cap", cap_value_o, 32'd0);
    check32("rst_capok", {31'd0, capok_o}, 32'd0);
    check32("rst_qerr", {31'd0, quad_err_o}, 32'd0);
    n_rst = 1'b1;
    tick(100);
    check32("init_ecd", ecd_value_o, 32'd0);
    check32("init_qerr", {31'd0, quad_err_o}, 32'd0);

    repeat (400) step(1);
    check32("fwd400", ecd_value_o, 32'd400);
    repeat (401) step(-1);
    check32("rev_wrap", ecd_value_o, 32'hFFFF_FFFF);

    preset(32'hFFFF_FFFE);
    repeat (3) step(1);
    check32("preset_wrap", ecd_value_o, 32'd1);
    tick(50);
    check32("held_no_represet", ecd_value_o, 32'd1);

    for (int g = 0; g < 4; g++) begin
      glen = $urandom_range(FILT_LEN - 1, 1);
      @(negedge clk_100M);
      if (g[0]) enc_b = ~enc_b;
      else      enc_a = ~enc_a;
      tick(glen);
      if (g[0]) enc_b = ~enc_b;
      else      enc_a = ~enc_a;
      tick(20);
    end
    check32("glitch_ecd", ecd_value_o, model_cnt);
    check32("glitch_qerr", {31'd0, quad_err_o}, 32'd0);

    @(negedge clk_100M);
    enc_a = ~enc_a;
    enc_b = ~enc_b;
    phase = (phase + 2) & 3;
    tick(20);
    check32("illegal_ecd", ecd_value_o, model_cnt);
    check32("illegal_qerr", {31'd0, quad_err_o}, 32'd1);
    preset($urandom);
    check32("qerr_cleared", {31'd0, quad_err_o}, 32'd0);

    repeat (200) step(($urandom_range(1, 0) == 1) ? 1 : -1);
    check32("random_walk", ecd_value_o, model_cnt);

    // Capture: latch 1234, ignore a later edge at 1300, release with capen.
    preset(32'd1234);
    @(negedge clk_100M);
    capen = 1'b1;
    tick(3);
    @(negedge clk_100M);
    cap_in = 1'b1;
    tick(20);
    check32("cap_first", cap_value_o, 32'd1234);
    check32("capok_set", {31'd0, capok_o}, 32'd1);
    @(negedge clk_100M);
    cap_in = 1'b0;
    tick(20);
    preset(32'd1300);
    @(negedge clk_100M);
    cap_in = 1'b1;
    tick(20);
    check32("cap_ignored", cap_value_o, 32'd1234);
    check32("capok_held", {31'd0, capok_o}, 32'd1);
    @(negedge clk_100M);
    capen = 1'b0;
    @(negedge clk_100M);
    check32("capok_clear", {31'd0, capok_o}, 32'd0);

    // Capture edge coincident with a preset rise: latch the pre-preset count.
    @(negedge clk_100M);
    cap_in = 1'b0;
    tick(20);
    preset(32'd50);
    @(negedge clk_100M);
    ecdrst = 1'b0;
    ecdrst_value = 32'd0;
    capen = 1'b1;
    tick(3);
    @(negedge clk_100M);
    cap_in = 1'b1;
    tick(FILT_LEN + 1);
    @(negedge clk_100M);
    ecdrst = 1'b1;
    push_exp(32'd0, cyc + 1);
    model_cnt = 32'd0;
    tick(20);
    check32("cap_vs_preset", cap_value_o, 32'd50);
    check32("capok_coinc", {31'd0, capok_o}, 32'd1);
    check32("ecd_after_preset", ecd_value_o, 32'd0);

    tick(10);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
